// File: rtl/uart_send_queue.sv
// uart_send_queue
//   Buffers whole words (1..WIDTH/8 bytes each) in a DEPTH-entry FIFO and
//   serialises them into single-byte requests toward the UART transmitter.
//   Both sides use the en/content/busy request protocol.
//
// Parameters
//   WIDTH     word width in bits (multiple of 8, >= 8)
//   DEPTH     FIFO entries (power of 2, >= 2)
//   MSB_FIRST 0: least-significant byte first, 1: most-significant byte first
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req_en       one-cycle push request
//   req_content  word to send
//   req_len      bytes to send; 0 or > BYTES means BYTES
//   req_busy     FIFO full; pushes are ignored while high
//   tx_en        registered one-cycle pulse to the transmitter
//   tx_content   registered; [7:0] byte, [31:8] zero; holds between pulses
//   tx_busy      transmitter busy
//   idle         FIFO empty, FSM idle and no pulse in flight
//   drop_count   saturating count of ignored pushes (only with
//                UART_SQ_DROP_CNT_EN defined)
//
// Optional feature macro: UART_SQ_DROP_CNT_EN
//
// States
//   IDLE  | nothing to send, waiting for the FIFO to fill
//   LOAD  | pop FIFO head into the shift register
//   SEND  | wait for !tx_busy, then emit current byte
//   GUARD | one dead cycle covering the transmitter's busy rise latency
module uart_send_queue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0,
    localparam int BYTES    = WIDTH / 8,
    localparam int LEN_W    = $clog2(BYTES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_en,
    input  logic [WIDTH-1:0] req_content,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_busy,
    output logic             tx_en,
    output logic [31:0]      tx_content,
    input  logic             tx_busy,
    output logic             idle
`ifdef UART_SQ_DROP_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [LEN_W-1:0] len_mem  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [LEN_W-1:0] remaining;

    logic             push;
    logic             pop;
    logic             fifo_avail;
    logic [LEN_W-1:0] len_norm;
    logic [7:0]       cur_byte;

    assign req_busy = (count == CW'(DEPTH));
    assign push     = req_en && !req_busy;
    assign pop      = (state == S_LOAD);

    // A word pushed on this edge is already in memory when LOAD reads it,
    // so the FSM may leave IDLE/GUARD on the push itself; this gives the
    // two-cycle accept-to-first-pulse latency.
    assign fifo_avail = (count != '0) || push;

    assign len_norm = ((req_len == '0) || (req_len > LEN_W'(BYTES)))
                      ? LEN_W'(BYTES) : req_len;

    assign cur_byte = (MSB_FIRST != 0) ? shift_reg[WIDTH-1 -: 8] : shift_reg[7:0];

    assign idle = (count == '0) && (state == S_IDLE) && !tx_en;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= req_content;
            len_mem[wr_ptr]  <= len_norm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            remaining  <= '0;
            tx_en      <= 1'b0;
            tx_content <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fifo_avail) state <= S_LOAD;
                end
                S_LOAD: begin
                    shift_reg <= data_mem[rd_ptr];
                    remaining <= len_mem[rd_ptr];
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_en      <= 1'b1;
                        tx_content <= {24'd0, cur_byte};
                        remaining  <= remaining - LEN_W'(1);
                        state      <= S_GUARD;
                    end
                end
                default: begin
                    if (remaining != '0) begin
                        shift_reg <= (MSB_FIRST != 0) ? (shift_reg << 8) : (shift_reg >> 8);
                        state     <= S_SEND;
                    end else if (fifo_avail) begin
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef UART_SQ_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (req_en && req_busy && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_send_queue.sv
// Bench for uart_send_queue: one LSB-first and one MSB-first instance share
// the same stimulus; each has its own expected-byte queue filled at push time
// and drained by a negedge monitor on every tx_en pulse.
module tb_uart_send_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_en = 1'b0;
    logic [31:0] req_content = '0;
    logic [2:0]  req_len = '0;
    logic        tx_busy = 1'b0;

    logic [1:0]       tx_en_v;
    logic [1:0]       rb_v;
    logic [1:0]       idle_v;
    logic [1:0][31:0] txc_v;
`ifdef UART_SQ_DROP_CNT_EN
    logic [1:0][15:0] drop_v;
`endif

    always #5 clk = ~clk;

    uart_send_queue #(.WIDTH(32), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .req_en(req_en), .req_content(req_content),
        .req_len(req_len), .req_busy(rb_v[0]), .tx_en(tx_en_v[0]),
        .tx_content(txc_v[0]), .tx_busy(tx_busy), .idle(idle_v[0])
`ifdef UART_SQ_DROP_CNT_EN
        , .drop_count(drop_v[0])
`endif
    );

    uart_send_queue #(.WIDTH(32), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .req_en(req_en), .req_content(req_content),
        .req_len(req_len), .req_busy(rb_v[1]), .tx_en(tx_en_v[1]),
        .tx_content(txc_v[1]), .tx_busy(tx_busy), .idle(idle_v[1])
`ifdef UART_SQ_DROP_CNT_EN
        , .drop_count(drop_v[1])
`endif
    );

    int n_checks = 0;
    int n_pass = 0;
    int dropped = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [1:0] prev_en = '0;
    logic       prev_busy = 1'b0;

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    endtask

    // Reference: normalise length, then list bytes in send order.
    task automatic expect_word(input logic [31:0] w, input logic [2:0] l);
        int n;
        n = (l == 0 || l > 4) ? 4 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp0.push_back(w[8*i +: 8]);
            exp1.push_back(w[8*(3-i) +: 8]);
        end
    endtask

    task automatic mon_one(input int d);
        logic [7:0] e;
        if (tx_en_v[d]) begin
            check(d == 0 ? "pulse_rule_lsb" : "pulse_rule_msb",
                  !(prev_en[d] || prev_busy), {prev_en[d], prev_busy}, 0);
            check(d == 0 ? "upper_zero_lsb" : "upper_zero_msb",
                  txc_v[d][31:8] == 24'd0, txc_v[d], {24'd0, txc_v[d][7:0]});
            if ((d == 0 ? exp0.size() : exp1.size()) == 0) begin
                check(d == 0 ? "unexpected_pulse_lsb" : "unexpected_pulse_msb",
                      1'b0, txc_v[d], 0);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                check(d == 0 ? "byte_lsb" : "byte_msb", txc_v[d][7:0] == e,
                      txc_v[d][7:0], e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_en   <= '0;
            prev_busy <= 1'b0;
        end else begin
            mon_one(0);
            mon_one(1);
            prev_en   <= tx_en_v;
            prev_busy <= tx_busy;
        end
    end

    task automatic push(input logic [31:0] w, input logic [2:0] l);
        @(posedge clk); #1;
        req_en = 1'b1; req_content = w; req_len = l;
        expect_word(w, l);
        @(posedge clk); #1;
        req_en = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk); #1;
            tx_busy = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (idle_v == 2'b11 && exp0.size() == 0 && exp1.size() == 0) done = 1'b1;
        end
        tx_busy = 1'b0;
        check("drained", done, {exp0.size(), exp1.size()}, 0);
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (tx_en_v[0]) ok = 1'b1;
        end
        check("pulse_timeout", ok, 0, 1);
    endtask

    // Burst of k consecutive pushes into an idle block with the transmitter
    // stalled: one word lands in the shift register and DEPTH in the FIFO.
    task automatic burst(input int k);
        logic [31:0] w;
        logic [2:0]  l;
        tx_busy = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= k; j++) begin
            w = $urandom;
            l = 3'($urandom_range(0, 7));
            req_en = 1'b1; req_content = w; req_len = l;
            if (j <= DEPTH + 1) expect_word(w, l);
            else dropped++;
            @(posedge clk); #1;
            check("req_busy", rb_v == {2{j >= DEPTH + 1}}, rb_v, {2{j >= DEPTH + 1}});
        end
        req_en = 1'b0;
`ifdef UART_SQ_DROP_CNT_EN
        check("drop_count", drop_v[0] == 16'(dropped) && drop_v[1] == 16'(dropped),
              drop_v, {16'(dropped), 16'(dropped)});
`endif
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", tx_en_v == 2'b00, tx_en_v, 0);
        check("rst_tx_content", txc_v == '0, txc_v[0], 0);
        check("rst_req_busy", rb_v == 2'b00, rb_v, 0);
        check("rst_idle", idle_v == 2'b11, idle_v, 3);
`ifdef UART_SQ_DROP_CNT_EN
        check("rst_drop", drop_v == '0, drop_v, 0);
`endif
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single word, timing of pulses relative to accept edge.
        push(32'h44332211, 3'd4);
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            check("pulse_timing", tx_en_v == {2{(j % 2 == 0) && j <= 8}},
                  tx_en_v, {2{(j % 2 == 0) && j <= 8}});
        end
        check("idle_after_word", idle_v == 2'b11, idle_v, 3);
        drain(0);

        // Partial lengths.
        push(32'hAABBCCDD, 3'd2);
        drain(0);
        push(32'hAABBCCDD, 3'd0);
        drain(0);

        // Backpressure between bytes.
        push(32'h00000201, 3'd2);
        wait_pulse(ok);
        tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_by_busy", exp0.size() == 1 && exp1.size() == 1, exp0.size(), 1);
        tx_busy = 1'b0;
        @(posedge clk); #1;
        check("pulse_after_busy", tx_en_v == 2'b11, tx_en_v, 3);
        drain(0);

        // Reset mid-word.
        push(32'h44332211, 3'd4);
        wait_pulse(ok);
        wait_pulse(ok);
        #2 reset = 1'b1;
        #1;
        exp0.delete();
        exp1.delete();
        dropped = 0;
        check("midrst_tx_en", tx_en_v == 2'b00, tx_en_v, 0);
        check("midrst_idle", idle_v == 2'b11, idle_v, 3);
        check("midrst_content", txc_v == '0, txc_v[0], 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_idle", idle_v == 2'b11, idle_v, 3);

        // Full FIFO, then randomized bursts.
        burst(6);
        drain(1);
        for (int p = 0; p < 25; p++) begin
            burst($urandom_range(1, 6));
            drain(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
